// File: rtl/bg_scroll_render.sv
// rtl/bg_scroll_render.sv - two-stage scrolling background renderer (sky, grass, dirt bands)
// Optional parallax cloud layer compiled in with BG_CLOUD_EN.
module bg_scroll_render #(
   parameter int H_RES     = 640,
   parameter int SKY_END   = 140,
   parameter int GRASS_END = 150,
   parameter int DIRT_END  = 180,
   parameter int SPEED_W   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [9:0]         x,
   input  logic [9:0]         y,
   input  logic               de,
   input  logic               frame_start,
   input  logic               scroll_en,
   input  logic [SPEED_W-1:0] scroll_speed,
   output logic [7:0]         r,
   output logic [7:0]         g,
   output logic [7:0]         b,
   output logic               de_out,
   output logic [9:0]         scroll_x
);

   localparam logic [10:0] H_RES_W     = 11'(H_RES);
   localparam logic [9:0]  SKY_END_V   = 10'(SKY_END);
   localparam logic [9:0]  SKY_HALF_V  = 10'(SKY_END / 2);
   localparam logic [9:0]  TUFT_ROW_V  = 10'(SKY_END + 1);
   localparam logic [9:0]  GRASS_END_V = 10'(GRASS_END);
   localparam logic [9:0]  DIRT_END_V  = 10'(DIRT_END);

   logic [10:0] scroll_sum;
   logic [10:0] scroll_wrap;
   logic [10:0] pix_sum;
   logic [10:0] pix_wrap;
   logic        in_line;

   // Both operands are below H_RES, so a single conditional subtract wraps.
   always_comb begin
      scroll_sum  = {1'b0, scroll_x} + 11'(scroll_speed);
      scroll_wrap = (scroll_sum >= H_RES_W) ? scroll_sum - H_RES_W : scroll_sum;
      pix_sum     = {1'b0, x} + {1'b0, scroll_x};
      pix_wrap    = (pix_sum >= H_RES_W) ? pix_sum - H_RES_W : pix_sum;
      in_line     = ({1'b0, x} < H_RES_W);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scroll_x <= '0;
      end else if (frame_start && scroll_en) begin
         scroll_x <= scroll_wrap[9:0];
      end
   end

   logic [9:0] xs1;
   logic [9:0] y1;
   logic       v1;
   logic       cloud1;

`ifdef BG_CLOUD_EN
   logic [6:0] cloud_pos;
   logic       cloud_hit;

   // Clouds move at half the ground speed; the 128-pixel repeat is a free 7-bit wrap.
   always_comb begin
      cloud_pos = x[6:0] + scroll_x[7:1];
      cloud_hit = (cloud_pos < 7'd48) && (y >= 10'd30) && (y <= 10'd45);
   end
`else
   logic cloud_hit;
   assign cloud_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         xs1    <= '0;
         y1     <= '0;
         v1     <= 1'b0;
         cloud1 <= 1'b0;
      end else begin
         xs1    <= pix_wrap[9:0];
         y1     <= y;
         v1     <= de && in_line;
         cloud1 <= cloud_hit;
      end
   end

   logic [9:0]  dirt_dy;
   logic [1:0]  dirt_idx;
   logic [23:0] rgb_next;

   always_comb begin
      dirt_dy  = y1 - GRASS_END_V;
      dirt_idx = xs1[2:1] ^ dirt_dy[2:1];
      rgb_next = 24'h000000;
      if (!v1) begin
         rgb_next = 24'h000000;
      end else if (y1 >= GRASS_END_V && y1 < DIRT_END_V) begin
         case (dirt_idx)
            2'd0:    rgb_next = 24'h6B4A2F;
            2'd1:    rgb_next = 24'h8B653F;
            2'd2:    rgb_next = 24'hA07A50;
            default: rgb_next = 24'h707070;
         endcase
      end else if (y1 >= SKY_END_V && y1 < GRASS_END_V) begin
         if (y1 == SKY_END_V || (y1 == TUFT_ROW_V && xs1[3]))
            rgb_next = 24'h7FC83F;
         else
            rgb_next = 24'h55A02F;
      end else if (cloud1) begin
         rgb_next = 24'hFFFFFF;
      end else if (y1 < SKY_END_V) begin
         rgb_next = (y1 < SKY_HALF_V) ? 24'h87CEEB : 24'h5DADE2;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{xs1[9:4], xs1[0], dirt_dy[9:3], dirt_dy[0], scroll_sum[10], pix_wrap[10]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r      <= '0;
         g      <= '0;
         b      <= '0;
         de_out <= 1'b0;
      end else begin
         {r, g, b} <= rgb_next;
         de_out    <= v1;
      end
   end

endmodule

// File: tb/tb_bg_scroll_render.sv
// tb/tb_bg_scroll_render.sv - randomized and directed check of bg_scroll_render against a reference model
module tb_bg_scroll_render;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] x;
   logic [9:0] y;
   logic       de;
   logic       frame_start;
   logic       scroll_en;
   logic [2:0] scroll_speed;
   logic [7:0] r;
   logic [7:0] g;
   logic [7:0] b;
   logic       de_out;
   logic [9:0] scroll_x;
   logic [23:0] rgb;

   assign rgb = {r, g, b};

   always #5 clk = ~clk;

   bg_scroll_render dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .de(de),
      .frame_start(frame_start), .scroll_en(scroll_en), .scroll_speed(scroll_speed),
      .r(r), .g(g), .b(b), .de_out(de_out), .scroll_x(scroll_x)
   );

   int total = 0;
   int bad   = 0;

   int unsigned dirt_lut[4] = '{32'h6B4A2F, 32'h8B653F, 32'hA07A50, 32'h707070};
   int idx0[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
   int idx2[8] = '{1, 1, 2, 2, 3, 3, 0, 0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Colour of one pixel straight from the band rules, using plain integer arithmetic.
   function automatic int unsigned ref_color(input int px, input int py, input int s);
      int xs;
      int idx;
      xs = (px + s) % 640;
      if (py >= 150 && py < 180) begin
         idx = ((xs / 2) % 4) ^ (((py - 150) / 2) % 4);
         return dirt_lut[idx];
      end
      if (py >= 140 && py < 150) begin
         if (py == 140) return 32'h7FC83F;
         if (py == 141 && ((xs / 8) % 2) == 1) return 32'h7FC83F;
         return 32'h55A02F;
      end
      if (py < 140) return (py < 70) ? 32'h87CEEB : 32'h5DADE2;
      return 0;
   endfunction

   int hx[16];
   int hy[16];
   int hs[16];
   bit hde[16];
   bit hrst[16];
   int k = 0;
   int s_model = 0;
   bit armed = 0;

   // Record what the DUT sees at each rising edge and advance the scroll model.
   initial begin
      forever begin
         @(posedge clk);
         hx[k % 16]   = int'(x);
         hy[k % 16]   = int'(y);
         hde[k % 16]  = de;
         hrst[k % 16] = reset;
         hs[k % 16]   = s_model;
         if (reset) begin
            s_model = 0;
            armed   = 1;
         end else if (frame_start && scroll_en) begin
            s_model = (s_model + int'(scroll_speed)) % 640;
         end
         k++;
      end
   end

   initial begin
      int e;
      int p;
      bit exp_v;
      int unsigned exp_rgb;
      forever begin
         @(negedge clk);
         if (armed && k >= 2) begin
            e = (k - 1) % 16;
            p = (k - 2) % 16;
            exp_v = !hrst[e] && !hrst[p] && hde[p] && (hx[p] < 640);
            exp_rgb = exp_v ? ref_color(hx[p], hy[p], hs[p]) : 0;
            chk("model_de_out", {31'd0, de_out}, {31'd0, exp_v});
            chk("model_rgb", {8'd0, rgb}, exp_rgb);
            chk("model_scroll_x", {22'd0, scroll_x}, s_model);
         end
      end
   end

   task automatic step(input int xi, input int yi, input bit dei, input bit fsi,
                       input bit eni, input int spi, input bit rsti);
      x            = 10'(xi);
      y            = 10'(yi);
      de           = dei;
      frame_start  = fsi;
      scroll_en    = eni;
      scroll_speed = 3'(spi);
      reset        = rsti;
      @(negedge clk);
   endtask

   initial begin
      int rx;
      int ry;
      reset = 1'b1; x = '0; y = '0; de = 1'b0;
      frame_start = 1'b1; scroll_en = 1'b1; scroll_speed = 3'd5;
      @(negedge clk);
      chk("reset_scroll_x", {22'd0, scroll_x}, 0);
      chk("reset_de_out", {31'd0, de_out}, 0);
      chk("reset_rgb", {8'd0, rgb}, 0);

      step(0, 10, 1, 0, 0, 0, 0);
      step(0, 100, 1, 0, 0, 0, 0);
      chk("sky_top_de", {31'd0, de_out}, 1);
      chk("sky_top_rgb", {8'd0, rgb}, 32'h87CEEB);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("sky_low_rgb", {8'd0, rgb}, 32'h5DADE2);

      for (int i = 0; i < 91; i++) step(0, 0, 0, 1, 1, 7, 0);
      step(0, 0, 0, 1, 1, 1, 0);
      chk("scroll_638", {22'd0, scroll_x}, 638);
      step(0, 0, 0, 1, 1, 5, 0);
      chk("scroll_wrap_3", {22'd0, scroll_x}, 3);
      step(0, 0, 0, 1, 1, 0, 0);
      chk("scroll_speed0", {22'd0, scroll_x}, 3);
      step(0, 0, 0, 1, 0, 6, 0);
      chk("scroll_en0", {22'd0, scroll_x}, 3);

      step(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 9; i++) begin
         step((i < 8) ? i : 0, 150, i < 8, 0, 0, 0, 0);
         if (i > 0) chk("dirt_s0", {8'd0, rgb}, dirt_lut[idx0[i-1]]);
      end
      step(0, 0, 0, 1, 1, 2, 0);
      chk("scroll_2", {22'd0, scroll_x}, 2);
      for (int i = 0; i < 9; i++) begin
         step((i < 8) ? i : 0, 150, i < 8, 0, 0, 0, 0);
         if (i > 0) chk("dirt_s2", {8'd0, rgb}, dirt_lut[idx2[i-1]]);
      end

      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 150, 1, 1, 1, 4, 0);
      step(0, 150, 1, 0, 0, 0, 0);
      chk("fs_same_pixel", {8'd0, rgb}, 32'h6B4A2F);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("fs_next_pixel", {8'd0, rgb}, 32'hA07A50);

      step(0, 0, 0, 0, 0, 0, 1);
      step(8, 141, 1, 0, 0, 0, 0);
      step(0, 141, 1, 0, 0, 0, 0);
      chk("grass_tuft", {8'd0, rgb}, 32'h7FC83F);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("grass_plain", {8'd0, rgb}, 32'h55A02F);

      for (int i = 0; i < 4; i++) step(i, 10, 1, 0, 0, 0, 0);
      step(4, 10, 1, 0, 0, 0, 1);
      chk("midline_rst_de", {31'd0, de_out}, 0);
      chk("midline_rst_rgb", {8'd0, rgb}, 0);
      step(5, 10, 1, 0, 0, 0, 0);
      chk("resume_gap_de", {31'd0, de_out}, 0);
      step(6, 10, 1, 0, 0, 0, 0);
      chk("resume_de", {31'd0, de_out}, 1);
      chk("resume_rgb", {8'd0, rgb}, 32'h87CEEB);

      step(640, 10, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("x640_de", {31'd0, de_out}, 0);
      chk("x640_rgb", {8'd0, rgb}, 0);

      for (int i = 0; i < 2500; i++) begin
         rx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(640, 1023)) : int'($urandom_range(0, 639));
         ry = ($urandom_range(0, 1) == 1) ? int'($urandom_range(136, 186)) : int'($urandom_range(0, 1023));
         step(rx, ry, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), $urandom_range(0, 99) == 0);
      end

      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
